// File: rtl/serial_bit_source.sv
`default_nettype none
// ============================================================================
// Module   : serial_bit_source
// Function : Parallel-in, serial-out word streamer with a one-word holding
//            register so back-to-back words stream without an idle bit.
// Revision : 1.0 - initial release
// ============================================================================
module serial_bit_source #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             w,
  output logic             valid,
  output logic             last
);

  localparam int              c_CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CW-1:0] c_LAST_CNT = c_CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [WIDTH-1:0] w_shift_adv;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] w_hold_nxt;
  logic             r_hold_full;
  logic             w_hold_full_nxt;
  logic [c_CW-1:0]  r_count;
  logic [c_CW-1:0]  w_count_nxt;
  logic             w_cur_bit;
  logic             w_accept;
  logic             w_at_last;

  // Bit order: the outgoing bit always sits at one end of the shift register
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_cur_bit   = r_shift[WIDTH-1];
      assign w_shift_adv = {r_shift[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_cur_bit   = r_shift[0];
      assign w_shift_adv = {1'b0, r_shift[WIDTH-1:1]};
    end
  endgenerate

  // A word is only taken while the hold register is free
  assign w_accept  = load & ~r_hold_full;
  assign w_at_last = (r_count == c_LAST_CNT);

  // All outputs derive from registers only; w is forced low outside a word
  assign valid = (r_state == S_SHIFT);
  assign w     = valid & w_cur_bit;
  assign last  = valid & w_at_last;
  assign ready = ~r_hold_full;

  // Next-state logic: bypass load when idle or at the last bit, otherwise queue in hold
  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    w_count_nxt     = r_count;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_shift_nxt = din;
          w_count_nxt = '0;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!w_at_last) begin
          w_shift_nxt = w_shift_adv;
          w_count_nxt = r_count + 1'b1;
          if (w_accept) begin
            w_hold_nxt      = din;
            w_hold_full_nxt = 1'b1;
          end
        end else if (r_hold_full) begin
          w_shift_nxt     = r_hold;
          w_hold_full_nxt = 1'b0;
          w_count_nxt     = '0;
        end else if (w_accept) begin
          w_shift_nxt = din;
          w_count_nxt = '0;
        end else begin
          w_count_nxt = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  // State register; reset aborts any word in flight and drops the queued word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_count     <= w_count_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_bit_source.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_bit_source
// Function : Directed self-checking bench for serial_bit_source (MSB-first
//            8-bit instance and LSB-first 4-bit instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_bit_source;

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] din;
  logic       ready, w, valid, last;
  logic       load4;
  logic [3:0] din4;
  logic       ready4, w4, valid4, last4;

  int n_checks;
  int n_pass;

  logic [7:0]  pat1;
  logic [23:0] exp_stream;

  serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .din   (din),
    .ready (ready),
    .w     (w),
    .valid (valid),
    .last  (last)
  );

  serial_bit_source #(.WIDTH(4), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk   (clk),
    .rst   (rst),
    .load  (load4),
    .din   (din4),
    .ready (ready4),
    .w     (w4),
    .valid (valid4),
    .last  (last4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1; load = 1'b0; din = '0; load4 = 1'b0; din4 = '0;
    pat1       = 8'b0101_0101;
    exp_stream = {8'hA5, 8'h3C, 8'h81};
    repeat (2) step();
    rst = 1'b0;

    // Reset state
    check("rst_w",     {31'd0, w},     32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_last",  {31'd0, last},  32'd0);
    check("rst_ready", {31'd0, ready}, 32'd1);
    step();
    check("idle_valid", {31'd0, valid}, 32'd0);

    // Single word 0x55, MSB first
    din = 8'h55; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("single_w[%0d]", i),     {31'd0, w},     {31'd0, pat1[7-i]});
      check($sformatf("single_valid[%0d]", i), {31'd0, valid}, 32'd1);
      check($sformatf("single_last[%0d]", i),  {31'd0, last},  (i == 7) ? 32'd1 : 32'd0);
      step();
    end
    check("single_end_valid", {31'd0, valid}, 32'd0);
    check("single_end_w",     {31'd0, w},     32'd0);
    check("single_end_last",  {31'd0, last},  32'd0);

    // Back-to-back A5/3C, overrun with FF, bypass of 81 at the last bit
    din = 8'hA5; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 24; i++) begin
      check($sformatf("stream_w[%0d]", i),     {31'd0, w},     {31'd0, exp_stream[23-i]});
      check($sformatf("stream_valid[%0d]", i), {31'd0, valid}, 32'd1);
      check($sformatf("stream_last[%0d]", i),  {31'd0, last},  ((i % 8) == 7) ? 32'd1 : 32'd0);
      check($sformatf("stream_ready[%0d]", i), {31'd0, ready}, (i >= 2 && i <= 7) ? 32'd0 : 32'd1);
      load = 1'b0;
      if (i == 1)  begin load = 1'b1; din = 8'h3C; end
      if (i == 4)  begin load = 1'b1; din = 8'hFF; end
      if (i == 15) begin load = 1'b1; din = 8'h81; end
      step();
    end
    load = 1'b0;
    check("stream_end_valid", {31'd0, valid}, 32'd0);
    check("stream_end_w",     {31'd0, w},     32'd0);
    check("stream_end_ready", {31'd0, ready}, 32'd1);

    // LSB first, WIDTH=4, 4'b0001
    din4 = 4'b0001; load4 = 1'b1;
    step();
    load4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("lsb_w[%0d]", i),     {31'd0, w4},     (i == 0) ? 32'd1 : 32'd0);
      check($sformatf("lsb_valid[%0d]", i), {31'd0, valid4}, 32'd1);
      check($sformatf("lsb_last[%0d]", i),  {31'd0, last4},  (i == 3) ? 32'd1 : 32'd0);
      step();
    end
    check("lsb_end_valid", {31'd0, valid4}, 32'd0);

    // Reset mid-word with 0x0F queued in hold
    din = 8'hF0; load = 1'b1;
    step();
    check("rmw_b0_w", {31'd0, w}, 32'd1);
    din = 8'h0F; load = 1'b1;
    step();
    load = 1'b0;
    check("rmw_b1_w",     {31'd0, w},     32'd1);
    check("rmw_b1_ready", {31'd0, ready}, 32'd0);
    step();
    check("rmw_b2_w", {31'd0, w}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rmw_rst_w",     {31'd0, w},     32'd0);
    check("rmw_rst_valid", {31'd0, valid}, 32'd0);
    check("rmw_rst_ready", {31'd0, ready}, 32'd1);
    check("rmw_rst_last",  {31'd0, last},  32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("rmw_after_valid[%0d]", i), {31'd0, valid}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
